mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one 32-bit memory port between instruction fetch (port A) and data
//  access (port B) in the pipelined datapath. Arbitrates requests, captures the
//  winner's address/data, and runs a multi-cycle req/ack transaction to memory.
//  Drives Sel, the control input of the 32-bit 2:1 address/data mux (0=A, 1=B).
//  Returns read data with a one-cycle done pulse; bounds each transaction with a timeout.
// PARAMETERS
//  WIDTH     32  data/address width
//  WAIT_MAX  15  max cycles in SERVE without MemAck before abort (1..2^CNT_W-1)
//  CNT_W      4  wait-counter width
// PORTS
//  Clk        in   1      clock, rising edge
//  Rst        in   1      asynchronous, active-low reset
//  ReqA       in   1      fetch request; held until DoneA/ErrA
//  AddrA      in   WIDTH  fetch address
//  ReqB       in   1      data request; held until DoneB/ErrB
//  AddrB      in   WIDTH  data address
//  WrB        in   1      1=write, 0=read (port B only)
//  WDataB     in   WIDTH  write data
//  MemReq     out  1      memory transaction active
//  MemAddr    out  WIDTH  registered address to memory
//  MemWr      out  1      registered write enable
//  MemWData   out  WIDTH  registered write data
//  MemAck     in   1      memory completion strobe
//  MemRData   in   WIDTH  memory read data, valid with MemAck
//  Sel        out  1      mux control: 0=port A, 1=port B
//  GntA/GntB  out  1      grant, high for whole transaction
//  DoneA/DoneB out 1      one-cycle completion pulse
//  ErrA/ErrB  out  1      one-cycle timeout pulse
//  RData      out  WIDTH  registered read data, valid with Done*
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (Sel=0, RData=0, MemAddr/WData=0); LastGnt=1, cnt=0.
//  - FSM: IDLE -> SERVE on any request (edge k); SERVE -> IDLE on MemAck or cnt==WAIT_MAX.
//  - Grant at edge k: Gnt*, MemReq, Sel, MemAddr, MemWr, MemWData registered from winner;
//    visible cycle k+1. Port A always MemWr=0, MemWData=0.
//  - Tie (ReqA&ReqB in IDLE): round robin -- grant port != LastGnt; LastGnt updated at grant.
//    First tie after reset goes to A.
//  - SERVE: cnt increments each cycle without MemAck; inputs ignored; MemAddr/Sel stable.
//  - MemAck sampled high at edge m: Gnt*/MemReq drop, Done* pulses, RData<=MemRData (reads;
//    writes leave RData unchanged), all visible cycle m+1. Next grant earliest edge m+1
//    (one IDLE cycle between back-to-back transactions).
//  - Timeout (cnt==WAIT_MAX, no MemAck): abort, Err* pulses, no Done*, RData unchanged.
//    MemAck and timeout same edge: MemAck wins.
//  - Requester dropping Req mid-SERVE: transaction completes; Done* still pulses.
//  - MemAck while IDLE: ignored.
//  - Sel holds last granted value in IDLE (no glitch on mux).
//  - Rst low mid-transaction: immediate return to reset values; no Done/Err pulse.
// CONFIGURATION
//  ARB_DATA_PRIORITY_EN defined: ties always granted to B (data), LastGnt unused;
//  starvation of A acceptable (pipeline stalls fetch during MEM access).
//  Undefined: round robin as above.
// TESTING
//  1 Reset: Rst=0 async mid-cycle -> all outputs 0, Sel=0 immediately.
//  2 ReqA only, AddrA=0x00400000, MemAck 3 cycles after MemReq, MemRData=0x8C080004
//    -> Sel=0, MemAddr=0x00400000, DoneA one cycle, RData=0x8C080004.
//  3 ReqA&ReqB same cycle repeated -> grants A,B,A,B; with ARB_DATA_PRIORITY_EN B,B,B.
//  4 ReqB write, AddrB=0x10010000, WDataB=0xDEADBEEF -> Sel=1, MemWr=1,
//    MemWData=0xDEADBEEF; DoneB on ack; RData unchanged.
//  5 ReqB, no MemAck -> ErrB pulse exactly WAIT_MAX=15 cycles after MemReq rises; IDLE.
//  6 Rst low during SERVE, then release -> IDLE, no Done/Err, next ReqA granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two requesters, the shared memory port and the arbiter.
// master: the arbiter itself; slave: the requesters and memory around it.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_a;
  logic [WIDTH-1:0] addr_a;
  logic             req_b;
  logic [WIDTH-1:0] addr_b;
  logic             wr_b;
  logic [WIDTH-1:0] wdata_b;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_wr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic             sel;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic             err_a;
  logic             err_b;
  logic [WIDTH-1:0] rdata;

  modport master (
    input  req_a, addr_a, req_b, addr_b, wr_b, wdata_b, mem_ack, mem_rdata,
    output mem_req, mem_addr, mem_wr, mem_wdata, sel,
    output gnt_a, gnt_b, done_a, done_b, err_a, err_b, rdata
  );

  modport slave (
    output req_a, addr_a, req_b, addr_b, wr_b, wdata_b, mem_ack, mem_rdata,
    input  mem_req, mem_addr, mem_wr, mem_wdata, sel,
    input  gnt_a, gnt_b, done_a, done_b, err_a, err_b, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (A) and data (B) with a bounded req/ack transaction.
// Define ARB_DATA_PRIORITY_EN to grant ties to B always; otherwise ties alternate round robin.
module mem_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.master bus
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pick_b;

`ifdef ARB_DATA_PRIORITY_EN
  always_comb begin
    pick_b = bus.req_b;
  end
`else
  logic last_gnt;

  // B wins alone, or on a tie when A had the previous grant.
  always_comb begin
    pick_b = bus.req_b & (~bus.req_a | ~last_gnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE && (bus.req_a || bus.req_b)) begin
      last_gnt <= pick_b;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= {WIDTH{1'b0}};
      bus.mem_wr    <= 1'b0;
      bus.mem_wdata <= {WIDTH{1'b0}};
      bus.sel       <= 1'b0;
      bus.gnt_a     <= 1'b0;
      bus.gnt_b     <= 1'b0;
      bus.done_a    <= 1'b0;
      bus.done_b    <= 1'b0;
      bus.err_a     <= 1'b0;
      bus.err_b     <= 1'b0;
      bus.rdata     <= {WIDTH{1'b0}};
    end else begin
      bus.done_a <= 1'b0;
      bus.done_b <= 1'b0;
      bus.err_a  <= 1'b0;
      bus.err_b  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            state         <= SERVE;
            cnt           <= CNT_W'(1);
            bus.mem_req   <= 1'b1;
            bus.gnt_a     <= ~pick_b;
            bus.gnt_b     <= pick_b;
            bus.sel       <= pick_b;
            bus.mem_addr  <= pick_b ? bus.addr_b : bus.addr_a;
            bus.mem_wr    <= pick_b & bus.wr_b;
            bus.mem_wdata <= pick_b ? bus.wdata_b : {WIDTH{1'b0}};
          end
        end
        SERVE: begin
          // cnt numbers the SERVE cycles, so the abort lands WAIT_MAX cycles after mem_req rose.
          if (bus.mem_ack) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_wr  <= 1'b0;
            bus.gnt_a   <= 1'b0;
            bus.gnt_b   <= 1'b0;
            bus.done_a  <= bus.gnt_a;
            bus.done_b  <= bus.gnt_b;
            if (!bus.mem_wr) begin
              bus.rdata <= bus.mem_rdata;
            end
          end else if (cnt == CNT_W'(WAIT_MAX)) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.mem_req <= 1'b0;
            bus.mem_wr  <= 1'b0;
            bus.gnt_a   <= 1'b0;
            bus.gnt_b   <= 1'b0;
            bus.err_a   <= bus.gnt_a;
            bus.err_b   <= bus.gnt_b;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset corners, a vector table of
// transactions, then randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int WAIT_MAX = 15;
`ifdef ARB_DATA_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(32)) bus();

  mem_port_arbiter #(.WIDTH(32), .WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic        model_last;
  logic [31:0] model_rdata;

  typedef struct {
    logic        ra;
    logic        rb;
    logic        wr;
    logic [31:0] aa;
    logic [31:0] ab;
    logic [31:0] wd;
    logic [31:0] rd;
    int          delay;
    logic        drop;
    logic        exp_b;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ra, input logic rb, input logic wr,
                               input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] wd);
    bus.req_a   = ra;
    bus.req_b   = rb;
    bus.wr_b    = wr;
    bus.addr_a  = aa;
    bus.addr_b  = ab;
    bus.wdata_b = wd;
  endtask

  // One whole transaction: ack arrives `delay` cycles after mem_req rises, or never if beyond WAIT_MAX.
  task automatic runTxn(input vec_t v);
    int          last;
    logic [31:0] exp_addr;
    logic        ok;
    applyStimulus(v.ra, v.rb, v.wr, v.aa, v.ab, v.wd);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    exp_addr = v.exp_b ? v.ab : v.aa;
    checkOutput("gnt_a", bus.gnt_a, !v.exp_b);
    checkOutput("gnt_b", bus.gnt_b, v.exp_b);
    checkOutput("sel", bus.sel, v.exp_b);
    checkOutput("mem_req", bus.mem_req, 1);
    checkOutput("mem_addr", bus.mem_addr, exp_addr);
    checkOutput("mem_wr", bus.mem_wr, v.exp_b & v.wr);
    checkOutput("mem_wdata", bus.mem_wdata, v.exp_b ? v.wd : 32'h0);
    model_last = v.exp_b;
    last = (v.delay < WAIT_MAX) ? v.delay : WAIT_MAX;
    for (int j = 1; j <= last; j++) begin
      bus.mem_ack   = (j == v.delay);
      bus.mem_rdata = (j == v.delay) ? v.rd : $urandom;
      bus.addr_a    = $urandom;
      bus.addr_b    = $urandom;
      bus.wdata_b   = $urandom;
      if (v.drop) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
      @(negedge clk);
      if (j < last) begin
        checkOutput("mem_req_hold", bus.mem_req, 1);
        checkOutput("mem_addr_hold", bus.mem_addr, exp_addr);
        checkOutput("early_pulse", {bus.done_a, bus.done_b, bus.err_a, bus.err_b}, 0);
      end
    end
    ok = (v.delay <= WAIT_MAX);
    if (ok && !(v.exp_b && v.wr)) model_rdata = v.rd;
    checkOutput("done_a", bus.done_a, ok && !v.exp_b);
    checkOutput("done_b", bus.done_b, ok && v.exp_b);
    checkOutput("err_a", bus.err_a, !ok && !v.exp_b);
    checkOutput("err_b", bus.err_b, !ok && v.exp_b);
    checkOutput("gnt_end", {bus.gnt_a, bus.gnt_b}, 0);
    checkOutput("mem_req_end", bus.mem_req, 0);
    checkOutput("rdata", bus.rdata, model_rdata);
    applyStimulus(0, 0, 0, 0, 0, 0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("pulse_width", {bus.done_a, bus.done_b, bus.err_a, bus.err_b}, 0);
    checkOutput("idle_mem_req", bus.mem_req, 0);
    checkOutput("sel_hold", bus.sel, v.exp_b);
  endtask

  initial begin
    vec_t v;
    applyStimulus(0, 0, 0, 0, 0, 0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_gnt", {bus.gnt_a, bus.gnt_b}, 0);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_sel", bus.sel, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_pulses", {bus.done_a, bus.done_b, bus.err_a, bus.err_b, bus.mem_wr}, 0);

    // Stray ack while idle must not disturb anything.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checkOutput("idle_ack_rdata", bus.rdata, 0);
    checkOutput("idle_ack_done", {bus.done_a, bus.done_b}, 0);
    checkOutput("idle_ack_req", bus.mem_req, 0);

    // Asynchronous reset in the middle of a B write.
    applyStimulus(0, 1, 1, 0, 32'h20000000, 32'hA5A5A5A5);
    @(negedge clk);
    checkOutput("pre_rst_gnt_b", bus.gnt_b, 1);
    checkOutput("pre_rst_sel", bus.sel, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_gnt_b", bus.gnt_b, 0);
    checkOutput("async_mem_req", bus.mem_req, 0);
    checkOutput("async_sel", bus.sel, 0);
    checkOutput("async_mem_addr", bus.mem_addr, 0);
    checkOutput("async_mem_wdata", bus.mem_wdata, 0);
    checkOutput("async_mem_wr", bus.mem_wr, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_pulses", {bus.done_a, bus.done_b, bus.err_a, bus.err_b}, 0);
    checkOutput("post_rst_req", bus.mem_req, 0);
    model_last  = 1'b1;
    model_rdata = 32'h0;

    vecs[0] = '{ra:1, rb:1, wr:0, aa:32'h00001000, ab:32'h10000000, wd:0, rd:32'h11110000, delay:2,  drop:0, exp_b:PRIO};
    vecs[1] = '{ra:1, rb:1, wr:0, aa:32'h00001004, ab:32'h10000004, wd:0, rd:32'h22220000, delay:1,  drop:0, exp_b:1'b1};
    vecs[2] = '{ra:1, rb:1, wr:0, aa:32'h00001008, ab:32'h10000008, wd:0, rd:32'h33330000, delay:4,  drop:1, exp_b:PRIO};
    vecs[3] = '{ra:1, rb:1, wr:0, aa:32'h0000100C, ab:32'h1000000C, wd:0, rd:32'h44440000, delay:2,  drop:0, exp_b:1'b1};
    vecs[4] = '{ra:1, rb:0, wr:0, aa:32'h00400000, ab:32'h0,        wd:0, rd:32'h8C080004, delay:3,  drop:0, exp_b:1'b0};
    vecs[5] = '{ra:0, rb:1, wr:1, aa:32'h0, ab:32'h10010000, wd:32'hDEADBEEF, rd:32'h55555555, delay:1, drop:0, exp_b:1'b1};
    vecs[6] = '{ra:0, rb:1, wr:0, aa:32'h0, ab:32'h10010004, wd:0,   rd:32'h66666666, delay:20, drop:0, exp_b:1'b1};
    vecs[7] = '{ra:1, rb:0, wr:0, aa:32'h00400004, ab:32'h0,        wd:0, rd:32'hCAFEF00D, delay:15, drop:0, exp_b:1'b0};
    vecs[8] = '{ra:1, rb:1, wr:1, aa:32'h00400008, ab:32'h10010008, wd:32'h01020304, rd:32'h77777777, delay:5, drop:0, exp_b:1'b1};
    vecs[9] = '{ra:1, rb:1, wr:0, aa:32'h0040000C, ab:32'h1001000C, wd:0, rd:32'h88888888, delay:6,  drop:0, exp_b:PRIO};
    for (int i = 0; i < 10; i++) begin
      runTxn(vecs[i]);
    end

    // Randomized transactions; the winner follows from the arbitration rules and the previous grant.
    for (int i = 0; i < 40; i++) begin
      v.ra = 1'($urandom_range(0, 1));
      v.rb = 1'($urandom_range(0, 1));
      if (!v.ra && !v.rb) v.ra = 1'b1;
      v.wr    = 1'($urandom_range(0, 1));
      v.aa    = $urandom;
      v.ab    = $urandom;
      v.wd    = $urandom;
      v.rd    = $urandom;
      v.delay = $urandom_range(1, WAIT_MAX + 3);
      v.drop  = ($urandom_range(0, 3) == 0);
      if (v.ra && v.rb) v.exp_b = PRIO ? 1'b1 : !model_last;
      else              v.exp_b = v.rb;
      runTxn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
